// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_port_arbiter                                                         |
// | Round-robin arbiter sharing one memory port between I and D requesters.  |
// | Optional macro ARB_DATA_PRIORITY_EN: fixed priority, D always wins.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`ifndef DRAM_ADDRESS_SIZE
`define DRAM_ADDRESS_SIZE 32
`endif
`ifndef DRAM_WORD_SIZE
`define DRAM_WORD_SIZE 32
`endif

module mem_port_arbiter #(
  parameter int ADDR_W = `DRAM_ADDRESS_SIZE,
  parameter int DATA_W = `DRAM_WORD_SIZE,
  parameter int BE_W   = DATA_W / 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_req,
  input  logic              d_rw,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [BE_W-1:0]   d_byte_en,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_req,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [BE_W-1:0]   mem_byte_en,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BUSY_I = 2'd1,
    S_BUSY_D = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t r_state;
  logic   r_last_d;   // 1 when the most recent grant went to the D side
  logic   w_grant_d;
  logic   w_grant_i;

`ifdef ARB_DATA_PRIORITY_EN
  assign w_grant_d = d_req;
`else
  assign w_grant_d = d_req & (~i_req | ~r_last_d);
`endif
  assign w_grant_i = i_req & ~w_grant_d;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_last_d    <= 1'b1;
      mem_req     <= 1'b0;
      mem_rw      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_byte_en <= '0;
      i_ready     <= 1'b0;
      d_ready     <= 1'b0;
      i_rdata     <= '0;
      d_rdata     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_i) begin
            mem_req     <= 1'b1;
            mem_rw      <= 1'b0;
            mem_addr    <= i_addr;
            mem_wdata   <= '0;
            mem_byte_en <= '1;
            r_last_d    <= 1'b0;
            r_state     <= S_BUSY_I;
          end else if (w_grant_d) begin
            mem_req     <= 1'b1;
            mem_rw      <= d_rw;
            mem_addr    <= d_addr;
            mem_wdata   <= d_wdata;
            mem_byte_en <= d_byte_en;
            r_last_d    <= 1'b1;
            r_state     <= S_BUSY_D;
          end
        end
        S_BUSY_I: begin
          if (mem_ack) begin
            i_rdata <= mem_rdata;
            i_ready <= 1'b1;
            mem_req <= 1'b0;
            r_state <= S_RESP;
          end
        end
        S_BUSY_D: begin
          if (mem_ack) begin
            d_rdata <= mem_rdata;
            d_ready <= 1'b1;
            mem_req <= 1'b0;
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          // ready pulses were raised on the ack edge; drop them after one cycle
          i_ready <= 1'b0;
          d_ready <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mem_port_arbiter                                                      |
// | Directed + randomized bench with a transaction-level arbitration model.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_mem_port_arbiter;

  logic        clock;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ready;
  logic        d_req;
  logic        d_rw;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_byte_en;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        mem_req;
  logic        mem_rw;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byte_en;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int n_vec = 0;
  int n_err = 0;

  // reference model: which side was granted last, and the read data each side should hold
  int          m_last_side;   // 0 = I, 1 = D
  logic [31:0] m_i_rdata;
  logic [31:0] m_d_rdata;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clock(clock), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_req(d_req), .d_rw(d_rw), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_byte_en(d_byte_en), .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_req(mem_req), .mem_rw(mem_rw), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_byte_en(mem_byte_en),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Runs one transaction starting from an IDLE cycle whose requests are already driven.
  task automatic serve(input int dly, input logic [31:0] rd, input bit late_d,
                       input logic [31:0] late_addr, output bit own_d);
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [3:0]  e_be;
    logic        e_rw;
    if (i_req && d_req) begin
`ifdef ARB_DATA_PRIORITY_EN
      own_d = 1'b1;
`else
      own_d = (m_last_side == 0);
`endif
    end else begin
      own_d = d_req;
    end
    e_addr  = own_d ? d_addr : i_addr;
    e_rw    = own_d ? d_rw : 1'b0;
    e_be    = own_d ? d_byte_en : 4'hF;
    e_wdata = d_wdata;
    tick();
    chk("grant_req", mem_req, 1'b1);
    chk("grant_rw", mem_rw, e_rw);
    chk("grant_addr", mem_addr, e_addr);
    chk("grant_be", mem_byte_en, e_be);
    if (own_d) chk("grant_wdata", mem_wdata, e_wdata);
    chk("busy_ready", {i_ready, d_ready}, 2'b00);
    for (int j = 1; j <= dly; j++) begin
      if (late_d && j == 1) begin
        d_req = 1'b1; d_rw = 1'b0; d_addr = late_addr; d_byte_en = 4'hF;
      end
      mem_ack   = (j == dly);
      mem_rdata = (j == dly) ? rd : $urandom;
      tick();
      if (j < dly) begin
        chk("busy_hold_req", mem_req, 1'b1);
        chk("busy_hold_addr", mem_addr, e_addr);
      end
    end
    // RESP cycle: a stray ack here must be ignored
    mem_ack   = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    if (own_d) m_d_rdata = rd; else m_i_rdata = rd;
    m_last_side = own_d ? 1 : 0;
    chk("resp_req", mem_req, 1'b0);
    chk("resp_ready", {i_ready, d_ready}, {!own_d, own_d});
    chk("resp_i_rdata", i_rdata, m_i_rdata);
    chk("resp_d_rdata", d_rdata, m_d_rdata);
    if (own_d) d_req = 1'b0; else i_req = 1'b0;
    tick();
    mem_ack = 1'b0;
    chk("idle_ready", {i_ready, d_ready}, 2'b00);
    chk("idle_req", mem_req, 1'b0);
    chk("idle_rdata", {i_rdata, d_rdata}, {m_i_rdata, m_d_rdata});
  endtask

  initial begin
    bit own;
    reset = 1'b0; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_rw = 1'b0;
    d_addr = '0; d_wdata = '0; d_byte_en = '0; mem_rdata = '0; mem_ack = 1'b0;
    m_last_side = 1; m_i_rdata = '0; m_d_rdata = '0;
    tick(); tick();
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_fields", {mem_rw, mem_addr, mem_wdata, mem_byte_en}, '0);
    chk("rst_ready", {i_ready, d_ready}, 2'b00);
    chk("rst_rdata", {i_rdata, d_rdata}, '0);
    reset = 1'b1;
    tick();
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("idle_stray_ack_ready", {i_ready, d_ready}, 2'b00);
    chk("idle_stray_ack_req", mem_req, 1'b0);

    // I read, ack on second BUSY cycle
    i_req = 1'b1; i_addr = 32'h100;
    serve(2, 32'hDEADBEEF, 1'b0, '0, own);

    // D write
    d_req = 1'b1; d_rw = 1'b1; d_addr = 32'h2004; d_wdata = 32'h12345678; d_byte_en = 4'b0011;
    serve(1, 32'h0BADF00D, 1'b0, '0, own);

    // tie, both held, immediate ack; owner re-requests in the following IDLE
    i_req = 1'b1; i_addr = 32'h300;
    d_req = 1'b1; d_rw = 1'b0; d_addr = 32'h400; d_byte_en = 4'hF;
    for (int t = 0; t < 4; t++) begin
      serve(1, $urandom, 1'b0, '0, own);
      if (t < 3) begin
        if (own) d_req = 1'b1; else i_req = 1'b1;
      end
    end
    serve(1, $urandom, 1'b0, '0, own);

    // D request arrives while I is busy with a slow ack
    i_req = 1'b1; i_addr = 32'h200;
    serve(5, 32'hCAFE0001, 1'b1, 32'h3000, own);
    chk("late_d_pending", d_req, 1'b1);
    serve(1, 32'hCAFE0002, 1'b0, '0, own);
    chk("late_d_served", own, 1'b1);

    // reset in the middle of a D transaction
    d_req = 1'b1; d_rw = 1'b0; d_addr = 32'h4000; d_byte_en = 4'hF;
    tick();
    chk("abort_grant", mem_req, 1'b1);
    tick();
    reset = 1'b0; d_req = 1'b0;
    tick();
    chk("abort_req", mem_req, 1'b0);
    chk("abort_ready", {i_ready, d_ready}, 2'b00);
    chk("abort_rdata", {i_rdata, d_rdata}, '0);
    reset = 1'b1;
    m_last_side = 1; m_i_rdata = '0; m_d_rdata = '0;
    for (int k = 0; k < 5; k++) begin
      mem_ack = 1'($urandom_range(0, 1));
      tick();
      chk("abort_quiet", {mem_req, i_ready, d_ready}, 3'b000);
    end
    mem_ack = 1'b0;
    i_req = 1'b1; i_addr = 32'h500;
    d_req = 1'b1; d_rw = 1'b1; d_addr = 32'h600; d_wdata = 32'h55AA55AA; d_byte_en = 4'b1100;
    serve(1, $urandom, 1'b0, '0, own);
`ifdef ARB_DATA_PRIORITY_EN
    chk("post_reset_tie", own, 1'b1);
`else
    chk("post_reset_tie", own, 1'b0);
`endif
    serve(1, $urandom, 1'b0, '0, own);

    // randomized traffic: waiting requests stay held, owners may re-request at once
    for (int t = 0; t < 40; t++) begin
      if (!i_req && $urandom_range(0, 1) == 1) begin
        i_req = 1'b1; i_addr = $urandom;
      end
      if (!d_req && $urandom_range(0, 1) == 1) begin
        d_req = 1'b1; d_rw = 1'($urandom_range(0, 1)); d_addr = $urandom;
        d_wdata = $urandom; d_byte_en = 4'($urandom_range(1, 15));
      end
      if (!i_req && !d_req) begin
        i_req = 1'b1; i_addr = $urandom;
      end
      serve($urandom_range(1, 4), $urandom, 1'b0, '0, own);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single external memory port between the instruction-side refill requester and the data-side requester of the memory subsystem.
- Sits between the icache/dcache miss logic and the DRAM model.
- Serialises single-word transactions with a registered request/acknowledge handshake.
- Uses round-robin arbitration, so neither side starves.

Parameters:
- ADDR_W, `DRAM_ADDRESS_SIZE: address width.
- DATA_W, `DRAM_WORD_SIZE: data word width.
- BE_W, DATA_W/8: byte-enable width.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- i_req  in  1  instruction-side request, held until i_ready.
- i_addr  in  ADDR_W  instruction-side word address.
- i_rdata  out  DATA_W  instruction-side read data, valid when i_ready=1.
- i_ready  out  1  one-cycle completion pulse for the instruction side.
- d_req  in  1  data-side request, held until d_ready.
- d_rw  in  1  data-side direction: 1=write, 0=read.
- d_addr  in  ADDR_W  data-side address.
- d_wdata  in  DATA_W  data-side write data.
- d_byte_en  in  BE_W  data-side byte enables.
- d_rdata  out  DATA_W  data-side read data, valid when d_ready=1.
- d_ready  out  1  one-cycle completion pulse for the data side.
- mem_req  out  1  memory request.
- mem_rw  out  1  memory direction: 1=write.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_byte_en  out  BE_W  memory byte enables.
- mem_rdata  in  DATA_W  memory read data.
- mem_ack  in  1  memory completion; data valid in the same cycle.

Behaviour:
- Reset: clock is the only clock. reset is synchronous and active-low: reset=0 at a rising edge forces the state defined here.
  - state=IDLE, last_grant=D (so the first tie goes to I).
  - All outputs 0: mem_req, mem_rw, mem_addr, mem_wdata, mem_byte_en, i_ready, d_ready, i_rdata, d_rdata.
- Reset mid-transaction: the transaction is abandoned and mem_req drops in the next cycle. No ready pulse is generated. The memory side must tolerate a dropped request.
- FSM states: IDLE, BUSY_I, BUSY_D, RESP.
- IDLE:
  - Only i_req=1: go to BUSY_I.
  - Only d_req=1: go to BUSY_D.
  - Both: grant the side that is not last_grant.
  - On grant, register the owner's address/rw/wdata/byte_en into the mem_* outputs, set mem_req=1, and update last_grant.
  - The I side always drives mem_rw=0 and mem_byte_en=all ones.
- BUSY_x:
  - mem_req stays 1 and the mem_* outputs stay stable.
  - mem_ack is sampled only in BUSY states.
  - On mem_ack=1: capture mem_rdata into the owner's rdata register, clear mem_req, go to RESP.
- RESP:
  - The owner's ready=1 for exactly one cycle; the other ready stays 0.
  - rdata holds its value until the next completion for that side.
  - Next state is IDLE.
  - For writes, rdata is still updated with mem_rdata (don't-care contents).
- Latency:
  - Request seen in IDLE at cycle 0: mem_req=1 at cycle 1.
  - mem_ack in cycle k: mem_req=0 and ready=1 in cycle k+1.
  - Arbitration is re-evaluated in cycle k+2 (IDLE).
  - Minimum turnaround: 3 cycles per transaction with mem_ack in the first BUSY cycle.
- Requester rule:
  - The owner deasserts req at the clock edge ending the RESP cycle.
  - It may reassert req in IDLE with a new request.
  - A req held high through IDLE after RESP is treated as a new request.
- Fairness: with both sides continuously requesting, grants alternate I,D,I,D. The maximum wait is one foreign transaction.
- Simultaneous events: a request arriving during BUSY/RESP is not lost. Request inputs are level-held, so they are evaluated in the next IDLE.
- mem_ack outside BUSY states is ignored.

Optional Feature:
- Macro: ARB_DATA_PRIORITY_EN.
- Defined: fixed priority. In IDLE, d_req=1 always wins over i_req. last_grant is still tracked but not used for ties. The instruction side can be delayed indefinitely by back-to-back data requests.
- Undefined: round-robin as specified in Behaviour.

Test Plan:
- Reset then I read: i_req=1, i_addr=0x100. Memory acks on the 2nd BUSY cycle with 0xDEADBEEF → mem_req=1 for 2 cycles with mem_addr=0x100, mem_rw=0, then i_ready=1 for 1 cycle with i_rdata=0xDEADBEEF; d_ready=0 throughout.
- D write: d_req=1, d_rw=1, d_addr=0x2004, d_wdata=0x12345678, d_byte_en=4'b0011 → mem_* carry exactly these values, mem_rw=1, and d_ready pulses the cycle after mem_ack.
- Tie from reset: i_req and d_req both asserted in the same cycle, both held, immediate ack → grant order I, D, I, D over 4 transactions, each ready a single-cycle pulse.
- Request during busy: d_req rises while BUSY_I, with ack delayed 5 cycles → the D grant begins in the IDLE after the I RESP and no request is dropped.
- Reset mid-transaction: reset=0 during BUSY_D → next cycle mem_req=0, all ready signals 0, state IDLE, and no ready pulse ever appears for the aborted transaction.
- With ARB_DATA_PRIORITY_EN defined, both sides requesting continuously for 3 transactions → all 3 grants go to D; i_ready first appears only after d_req is dropped.
